// File: rtl/pes_gray_pkg.sv
// rtl/pes_gray_pkg.sv - shared width default and binary/Gray conversion functions
package pes_gray_pkg;

    // Default code width; legal widths are 2..32.
    localparam int GRAY_WIDTH_DEFAULT = 4;
    localparam int GRAY_WIDTH_MAX     = 32;

    // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
    function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(input logic [GRAY_WIDTH_MAX-1:0] v);
        return v ^ (v >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    // Zero-extended narrower codes convert correctly because the upper bits are zero.
    function automatic logic [GRAY_WIDTH_MAX-1:0] gray2bin(input logic [GRAY_WIDTH_MAX-1:0] v);
        logic [GRAY_WIDTH_MAX-1:0] r;
        r[GRAY_WIDTH_MAX-1] = v[GRAY_WIDTH_MAX-1];
        for (int i = GRAY_WIDTH_MAX - 2; i >= 0; i--) begin
            r[i] = r[i+1] ^ v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/pes_bin2gray_enc.sv
// rtl/pes_bin2gray_enc.sv - combinational binary to Gray encoder
module pes_bin2gray_enc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // MSB passes straight through; it has no upper neighbour.
    assign gray[WIDTH-1] = bin[WIDTH-1];

    // Remaining bits are pure XORs of adjacent binary bits, no carries involved.
    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_bit
        assign gray[i] = bin[i+1] ^ bin[i];
    end

endmodule

// File: rtl/pes_binary_to_gray_converter.sv
// rtl/pes_binary_to_gray_converter.sv - registered binary to Gray converter
module pes_binary_to_gray_converter
    import pes_gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g
);

    logic [WIDTH-1:0] w_g_next;
    logic [WIDTH-1:0] r_g;

    pes_bin2gray_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .bin  (b),
        .gray (w_g_next)
    );

    // Output register: cleared asynchronously by rst, otherwise loads the encoding every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g <= '0;
        end else begin
            r_g <= w_g_next;
        end
    end

    // g comes only from the flop, so it never glitches on b transitions.
    assign g = r_g;

endmodule

// File: tb/tb_pes_binary_to_gray_converter.sv
// tb/tb_pes_binary_to_gray_converter.sv - directed self-checking bench for the Gray converter
module tb_pes_binary_to_gray_converter;
    import pes_gray_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] b   = 4'd0;
    logic [3:0] g;
    logic [7:0] b8  = 8'd0;
    logic [7:0] g8;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_sweep [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                   4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    pes_binary_to_gray_converter #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .b   (b),
        .g   (g)
    );

    pes_binary_to_gray_converter #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .b   (b8),
        .g   (g8)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        #1 rst = 1'b1;
        b  = 4'b0101;
        #1;
        total++;
        if (g !== 4'b0000) begin
            bad++;
            $display("FAIL reset_immediate: g=%b expected=%b", g, 4'b0000);
        end
        total++;
        if (g8 !== 8'h00) begin
            bad++;
            $display("FAIL reset_immediate_w8: g=%h expected=%h", g8, 8'h00);
        end
        @(posedge clk); #1;
        total++;
        if (g !== 4'b0000) begin
            bad++;
            $display("FAIL reset_held_edge: g=%b expected=%b", g, 4'b0000);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (g !== 4'b0111) begin
            bad++;
            $display("FAIL reset_release: g=%b expected=%b", g, 4'b0111);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] prev;
        prev = 4'd0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            b = 4'(k);
            @(posedge clk); #1;
            total++;
            if (g !== exp_sweep[k]) begin
                bad++;
                $display("FAIL sweep_value k=%0d: g=%0d expected=%0d", k, g, exp_sweep[k]);
            end
            total++;
            if (gray2bin(32'(g)) !== 32'(k)) begin
                bad++;
                $display("FAIL sweep_gray2bin k=%0d: got=%0d expected=%0d", k, gray2bin(32'(g)), k);
            end
            if (k > 0) begin
                total++;
                if ($countones(g ^ prev) != 1) begin
                    bad++;
                    $display("FAIL sweep_one_bit k=%0d: prev=%b g=%b", k, prev, g);
                end
            end
            prev = g;
        end
        @(negedge clk);
        b = 4'd0;
        @(posedge clk); #1;
        total++;
        if (g !== 4'd0 || $countones(g ^ prev) != 1) begin
            bad++;
            $display("FAIL sweep_wrap: prev=%b g=%b expected=%b", prev, g, 4'd0);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        b = 4'b0011;
        @(posedge clk); #1;
        total++;
        if (g !== 4'b0010) begin
            bad++;
            $display("FAIL latency_first: g=%b expected=%b", g, 4'b0010);
        end
        #2 b = 4'b1000;
        #1;
        total++;
        if (g !== 4'b0010) begin
            bad++;
            $display("FAIL latency_no_comb_path: g=%b expected=%b", g, 4'b0010);
        end
        @(negedge clk);
        total++;
        if (g !== 4'b0010) begin
            bad++;
            $display("FAIL latency_hold: g=%b expected=%b", g, 4'b0010);
        end
        @(posedge clk); #1;
        total++;
        if (g !== 4'b1100) begin
            bad++;
            $display("FAIL latency_update: g=%b expected=%b", g, 4'b1100);
        end
    endtask

    task automatic test_async_midstream();
        @(negedge clk);
        b = 4'b1111;
        @(posedge clk); #1;
        total++;
        if (g !== 4'b1000) begin
            bad++;
            $display("FAIL async_pre: g=%b expected=%b", g, 4'b1000);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (g !== 4'b0000) begin
            bad++;
            $display("FAIL async_clear: g=%b expected=%b", g, 4'b0000);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (g !== 4'b0000) begin
            bad++;
            $display("FAIL async_no_pending: g=%b expected=%b", g, 4'b0000);
        end
        @(posedge clk); #1;
        total++;
        if (g !== 4'b1000) begin
            bad++;
            $display("FAIL async_recover: g=%b expected=%b", g, 4'b1000);
        end
    endtask

    task automatic test_width8();
        @(negedge clk);
        b8 = 8'hFF;
        @(posedge clk); #1;
        total++;
        if (g8 !== 8'h80) begin
            bad++;
            $display("FAIL width8_ff: g=%h expected=%h", g8, 8'h80);
        end
        @(negedge clk);
        b8 = 8'hA5;
        @(posedge clk); #1;
        total++;
        if (g8 !== 8'hF7) begin
            bad++;
            $display("FAIL width8_a5: g=%h expected=%h", g8, 8'hF7);
        end
        @(negedge clk);
        b8 = 8'h01;
        @(posedge clk); #1;
        total++;
        if (g8 !== 8'h01) begin
            bad++;
            $display("FAIL width8_01: g=%h expected=%h", g8, 8'h01);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_latency();
        test_async_midstream();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
